// File: rtl/icache_mem_pkg.sv
// Shared types and widths for the icache refill memory responder.
package icache_mem_pkg;

    localparam int unsigned MEM_ADDR_W  = 14;
    localparam int unsigned MEM_DATA_W  = 32;
    localparam int unsigned LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// Word RAM with one synchronous read port and one synchronous write port.
// The read returns the pre-write word when both ports hit the same address.
module mem_word_ram
    import icache_mem_pkg::*;
#(
    parameter int unsigned WORDS = 16384
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [MEM_ADDR_W-1:0] rd_addr,
    output logic [MEM_DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [MEM_ADDR_W-1:0] wr_addr,
    input  logic [MEM_DATA_W-1:0] wr_data
);

    logic [MEM_DATA_W-1:0] mem [WORDS];

    // Both assignments are non-blocking, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/icache_mem_responder.sv
// Memory-side target of the icache refill interface: one outstanding read,
// acked after LATENCY cycles, with a backdoor load port and protocol checking.
module icache_mem_responder
    import icache_mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memory_stb,
    input  logic [MEM_ADDR_W-1:0] memory_addr,
    output logic [MEM_DATA_W-1:0] memory_data,
    output logic                  memory_ack,
    input  logic                  load_en,
    input  logic [MEM_ADDR_W-1:0] load_addr,
    input  logic [MEM_DATA_W-1:0] load_data,
    output logic                  busy,
    output logic                  proto_err,
    output logic [15:0]           req_count
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic                  proto_err_q, proto_err_d;
    logic [15:0]           req_count_q, req_count_d;
    logic                  rd_en;
    logic [MEM_ADDR_W-1:0] rd_addr;
    logic [MEM_DATA_W-1:0] rd_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        proto_err_d = proto_err_q;
        req_count_d = req_count_q;
        rd_en       = 1'b0;
        rd_addr     = addr_q;
        unique case (state_q)
            IDLE: begin
                if (memory_stb) begin
                    addr_d = memory_addr;
                    cnt_d  = LAT_M1;
                    if (LATENCY == 1) begin
                        // addr_q is not yet loaded, so read straight from the bus
                        state_d = ACK;
                        rd_en   = 1'b1;
                        rd_addr = memory_addr;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!memory_stb) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (memory_addr != addr_q) begin
                        proto_err_d = 1'b1;
                    end
                    if (cnt_q == 4'd1) begin
                        state_d = ACK;
                        rd_en   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ACK: begin
                state_d     = IDLE;
                req_count_d = req_count_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
            req_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
            req_count_q <= req_count_d;
        end
    end

    mem_word_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data)
    );

    // The RAM output is only meaningful while acking; mask it everywhere else.
    assign memory_ack  = (state_q == ACK);
    assign memory_data = memory_ack ? rd_data : '0;
    assign busy        = (state_q != IDLE);
    assign proto_err   = proto_err_q;
    assign req_count   = req_count_q;

endmodule
